matrix_mac_sequencer: RTL

//  Sequential, parametrised successor to the flat combinational multiplier: computes R = A x B for a

---
 rtl/matrix_mac_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/matrix_mac_sequencer.sv
// Sequential matrix multiplier R = A x B for a runtime size N (1..MATRIX_SIZE_MAX).
// One shared MAC datapath walks (i,j,k); each result element takes N MAC cycles
// plus one WRITE cycle. Results use signed or unsigned arithmetic. The overflow
// flag is sticky until the next accepted job.
// Optional build macro: MATMUL_SATURATE_EN. When it is defined, an out-of-range
// accumulate clamps to the extreme value for the mode. When it is not defined,
// the accumulator wraps.
module matrix_mac_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ACC_WIDTH       = 2*DATA_WIDTH+4,
  parameter int MATRIX_SIZE_MAX = 10,
  parameter int SIZE_W          = $clog2(MATRIX_SIZE_MAX+1)
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [SIZE_W-1:0]                                     matrix_size,
  input  logic                                                  signed_mode,
  input  logic [MATRIX_SIZE_MAX*MATRIX_SIZE_MAX*DATA_WIDTH-1:0] matrix_a,
  input  logic [MATRIX_SIZE_MAX*MATRIX_SIZE_MAX*DATA_WIDTH-1:0] matrix_b,
  output logic [MATRIX_SIZE_MAX*MATRIX_SIZE_MAX*ACC_WIDTH-1:0]  result_matrix,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  size_error,
  output logic                                                  overflow
);
  localparam int ELEMS = MATRIX_SIZE_MAX*MATRIX_SIZE_MAX;
  localparam int IDX_W = $clog2(ELEMS);
  localparam int EW    = ACC_WIDTH+1;

  // REJECT holds a refused request for one cycle.
  // This lines up done and size_error on the same edge distance as documented.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_REJECT, S_DONE} state_t;
  state_t state, state_nx;

  logic [ELEMS-1:0][DATA_WIDTH-1:0] a_q, b_q;
  logic [ELEMS-1:0][ACC_WIDTH-1:0]  res_q;
  logic [SIZE_W-1:0]                n_q, i_q, j_q, k_q;
  logic                             sgn_q, rej_q;
  logic [ACC_WIDTH-1:0]             acc_q, acc_nx;
  logic                             size_ok, k_last, j_last, i_last;
  logic [IDX_W-1:0]                 a_idx, b_idx, wr_idx;
  logic [DATA_WIDTH-1:0]            a_el, b_el;
  logic signed [DATA_WIDTH:0]       a_x, b_x;
  logic signed [2*DATA_WIDTH+1:0]   prod;
  logic signed [EW-1:0]             acc_x, prod_x, sum;
  logic                             ovf_step;

  assign size_ok = (matrix_size != '0) && (matrix_size <= SIZE_W'(MATRIX_SIZE_MAX));
  assign k_last  = (k_q == n_q - SIZE_W'(1));
  assign j_last  = (j_q == n_q - SIZE_W'(1));
  assign i_last  = (i_q == n_q - SIZE_W'(1));

  assign a_idx  = IDX_W'(i_q * MATRIX_SIZE_MAX + k_q);
  assign b_idx  = IDX_W'(k_q * MATRIX_SIZE_MAX + j_q);
  assign wr_idx = IDX_W'(i_q * MATRIX_SIZE_MAX + j_q);
  assign a_el   = a_q[a_idx];
  assign b_el   = b_q[b_idx];

  // A single signed multiplier serves both modes.
  // Operands are sign-extended in signed mode and zero-extended otherwise.
  assign a_x    = {sgn_q & a_el[DATA_WIDTH-1], a_el};
  assign b_x    = {sgn_q & b_el[DATA_WIDTH-1], b_el};
  assign prod   = a_x * b_x;
  assign prod_x = EW'(prod);
  assign acc_x  = {sgn_q & acc_q[ACC_WIDTH-1], acc_q};
  assign sum    = acc_x + prod_x;
  // The extra top bit of sum marks the out-of-range condition.
  // Unsigned: it is a carry out. Signed: it disagrees with the sign bit.
  assign ovf_step = sgn_q ? (sum[EW-1] != sum[EW-2]) : sum[EW-1];

  assign busy          = (state == S_LOAD) || (state == S_MAC) || (state == S_WRITE);
  assign result_matrix = res_q;

  // Next accumulator value: wrap by default, clamp when saturation is built in
  always_comb begin
    acc_nx = sum[ACC_WIDTH-1:0];
`ifdef MATMUL_SATURATE_EN
    if (ovf_step) begin
      if (!sgn_q)          acc_nx = '1;
      else if (sum[EW-1])  acc_nx = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                 acc_nx = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = size_ok ? S_LOAD : S_REJECT;
      S_LOAD:   state_nx = S_MAC;
      S_MAC:    if (k_last) state_nx = S_WRITE;
      S_WRITE:  state_nx = (i_last && j_last) ? S_DONE : S_MAC;
      S_REJECT: state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Datapath: operand capture, MAC, result writes, and status flags.
  // done is registered one cycle after DONE, so it lands on the documented edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q <= '0; b_q <= '0; res_q <= '0; acc_q <= '0;
      n_q <= '0; i_q <= '0; j_q <= '0; k_q <= '0;
      sgn_q <= 1'b0; rej_q <= 1'b0;
      done <= 1'b0; size_error <= 1'b0; overflow <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          rej_q <= !size_ok;
          if (size_ok) begin
            a_q <= matrix_a; b_q <= matrix_b;
            n_q <= matrix_size; sgn_q <= signed_mode;
            size_error <= 1'b0;
          end
        end
        S_LOAD: begin
          res_q <= '0; overflow <= 1'b0; acc_q <= '0;
          i_q <= '0; j_q <= '0; k_q <= '0;
        end
        S_MAC: begin
          acc_q <= acc_nx;
          if (ovf_step) overflow <= 1'b1;
          if (!k_last)  k_q <= k_q + SIZE_W'(1);
        end
        S_WRITE: begin
          res_q[wr_idx] <= acc_q;
          acc_q <= '0;
          k_q   <= '0;
          if (j_last) begin
            j_q <= '0;
            i_q <= i_q + SIZE_W'(1);
          end else begin
            j_q <= j_q + SIZE_W'(1);
          end
        end
        S_DONE:  size_error <= rej_q;
        default: ;
      endcase
    end
  end
endmodule
